// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID pipeline register
// and a saturating count of instructions accepted into IF/ID.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 32,
    localparam int unsigned XLEN    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic             PCSrcE,
    input  logic [XLEN-1:0]  PCTargetE,
    input  logic [XLEN-1:0]  InstrF,
    output logic [XLEN-1:0]  PCF,
    output logic [XLEN-1:0]  PCPlus4F,
    output logic [XLEN-1:0]  InstrD,
    output logic [XLEN-1:0]  PCD,
    output logic [XLEN-1:0]  PCPlus4D,
    output logic             ValidD,
    output logic             MisalignE,
    output logic [CNT_W-1:0] FetchCnt
);

    logic [XLEN-1:0] pc_next;
    logic            capture;
    logic            cnt_full;

    assign PCPlus4F = PCF + XLEN'(4);
    assign capture  = !FlushD && !StallD;
    assign cnt_full = (FetchCnt == {CNT_W{1'b1}});

    // Redirect beats stall; redirect targets are forced to a word boundary
    always_comb begin
        pc_next = PCPlus4F;
        if (PCSrcE) begin
            pc_next = {PCTargetE[XLEN-1:2], 2'b00};
        end else if (StallF) begin
            pc_next = PCF;
        end
    end

    // PC register and misaligned-redirect pulse
    always_ff @(posedge clk) begin
        if (!rst) begin
            PCF       <= RESET_PC;
            MisalignE <= 1'b0;
        end else begin
            PCF       <= pc_next;
            MisalignE <= PCSrcE && (PCTargetE[1:0] != 2'b00);
        end
    end

    // IF/ID register: flush beats stall
    always_ff @(posedge clk) begin
        if (!rst) begin
            InstrD   <= '0;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (FlushD) begin
            InstrD   <= '0;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (!StallD) begin
            InstrD   <= InstrF;
            PCD      <= PCF;
            PCPlus4D <= PCPlus4F;
            ValidD   <= 1'b1;
        end
    end

    // Accepted-instruction counter, sticks at all-ones
    always_ff @(posedge clk) begin
        if (!rst) begin
            FetchCnt <= '0;
        end else if (capture && !cnt_full) begin
            FetchCnt <= FetchCnt + CNT_W'(1);
        end
    end

endmodule
